// File: rtl/lamp_sqrt_unit_pkg.sv
// lamp_sqrt_unit_pkg: shared widths and FSM state type for the mantissa sqrt unit
package lamp_sqrt_unit_pkg;
    localparam int LAMP_FLOAT_F_DW = 7;
    localparam int LAMP_SQRT_RES_W = 2 * (1 + LAMP_FLOAT_F_DW);
    typedef enum logic [2:0] {IDLE, ROOT, DIV, DONE, BYP} sqrtState_t;
endpackage

// File: rtl/lamp_sqrt_rstep.sv
// lamp_sqrt_rstep: one restoring trial subtract, shared by the root and divide phases
module lamp_sqrt_rstep #(
    parameter int W = 18
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] trial_i,
    output logic [W-1:0] rem_o,
    output logic         bit_o
);
    assign bit_o = rem_i >= trial_i;
    assign rem_o = bit_o ? rem_i - trial_i : rem_i;
endmodule

// File: rtl/lamp_sqrt_unit.sv
// lamp_sqrt_unit: bit-serial mantissa sqrt / inverse sqrt, one result bit per cycle
module lamp_sqrt_unit
    import lamp_sqrt_unit_pkg::*;
#(
    parameter int MANT_W = 1 + LAMP_FLOAT_F_DW,
    parameter int RES_W  = 2 * MANT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              doSqrt_i,
    input  logic [MANT_W-1:0] s_i,
    input  logic              is_exp_odd_i,
    input  logic              invSqrt_i,
    input  logic              special_case_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic [RES_W-1:0]  res_o,
    output logic              sticky_o,
    output logic              valid_o
);
    localparam int CNT_W = $clog2(RES_W);
    localparam int REM_W = RES_W + 2;
    localparam int SHIFT = 2 * (RES_W - 1) - (MANT_W - 1);

    sqrtState_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*RES_W-1:0] rad, rad_in;
    logic [REM_W-1:0]   rem, step_rem, step_trial, step_rem_o;
    logic [RES_W-1:0]   q, d;
    logic               step_bit, inv, root_sticky, accept, last;

    assign ready_o = state == IDLE || state == DONE;
    assign valid_o = (state == DONE || state == BYP) && !flush_i;
    assign accept  = doSqrt_i && ready_o && !flush_i;
    assign last    = cnt == '0;
    assign rad_in  = {{(2*RES_W-MANT_W){1'b0}}, s_i} << (is_exp_odd_i ? SHIFT + 1 : SHIFT);
    // ROOT brings down two radicand bits against 4q+1; DIV brings down a zero against the root
    assign step_rem   = state == DIV ? {rem[REM_W-2:0], 1'b0} : {rem[REM_W-3:0], rad[2*RES_W-1 -: 2]};
    assign step_trial = state == DIV ? {2'b00, q} : {q, 2'b01};

    lamp_sqrt_rstep #(.W(REM_W)) u_rstep (
        .rem_i   (step_rem),
        .trial_i (step_trial),
        .rem_o   (step_rem_o),
        .bit_o   (step_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rad         <= '0;
            rem         <= '0;
            q           <= '0;
            d           <= '0;
            inv         <= 1'b0;
            root_sticky <= 1'b0;
            res_o       <= '0;
            sticky_o    <= 1'b0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (accept && special_case_i) begin
                        state    <= BYP;
                        res_o    <= '0;
                        sticky_o <= 1'b0;
                    end else if (accept) begin
                        state <= ROOT;
                        cnt   <= CNT_W'(RES_W - 1);
                        rad   <= rad_in;
                        rem   <= '0;
                        q     <= '0;
                        d     <= '0;
                        inv   <= invSqrt_i;
                    end
                end
                ROOT: begin
                    rad <= rad << 2;
                    rem <= step_rem_o;
                    q   <= {q[RES_W-2:0], step_bit};
                    cnt <= cnt - 1'b1;
                    if (last && inv) begin
                        state       <= DIV;
                        cnt         <= CNT_W'(RES_W - 1);
                        rem         <= REM_W'(1) << (RES_W - 2);
                        root_sticky <= step_rem_o != '0;
                    end else if (last) begin
                        state    <= DONE;
                        res_o    <= {q[RES_W-2:0], step_bit};
                        sticky_o <= step_rem_o != '0;
                    end
                end
                DIV: begin
                    rem <= step_rem_o;
                    d   <= {d[RES_W-2:0], step_bit};
                    cnt <= cnt - 1'b1;
                    if (last) begin
                        state    <= DONE;
                        res_o    <= {d[RES_W-2:0], step_bit};
                        sticky_o <= root_sticky || step_rem_o != '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lamp_sqrt_unit.sv
// tb_lamp_sqrt_unit: scoreboard against an arithmetic isqrt / reciprocal model
module tb_lamp_sqrt_unit;
    logic        clk_tb = 1'b0;
    logic        rst, do_sqrt, odd, inv, spc, flush;
    logic [7:0]  s;
    logic        ready, sticky, valid;
    logic [15:0] res;

    always #5 clk_tb = ~clk_tb;

    lamp_sqrt_unit #(.MANT_W(8), .RES_W(16)) dut (
        .clk            (clk_tb),
        .rst            (rst),
        .doSqrt_i       (do_sqrt),
        .s_i            (s),
        .is_exp_odd_i   (odd),
        .invSqrt_i      (inv),
        .special_case_i (spc),
        .flush_i        (flush),
        .ready_o        (ready),
        .res_o          (res),
        .sticky_o       (sticky),
        .valid_o        (valid)
    );

    typedef struct {
        logic [15:0] res;
        bit          st;
        bit          byp;
        int          due;
    } item_t;

    item_t       sb[$];
    item_t       it;
    int          checks = 0, errors = 0, cyc = 0;
    bit          chk = 0, due_now, exp_v, exp_r, st_hold, m_st;
    logic [15:0] res_hold, m_res;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void model(input logic [7:0] sv, input bit ov, input bit iv,
                                  output logic [15:0] r, output bit st);
        longint rr, qq, dd, one;
        one = longint'(1) << 30;
        rr  = (longint'(sv) * (ov ? 2 : 1)) << 23;
        qq  = 0;
        for (int b = 15; b >= 0; b--)
            if ((qq + (longint'(1) << b)) * (qq + (longint'(1) << b)) <= rr) qq += longint'(1) << b;
        if (!iv) begin
            r  = 16'(qq);
            st = rr != qq * qq;
        end else begin
            dd = one / qq;
            r  = 16'(dd);
            st = (rr != qq * qq) || (one % qq != 0);
        end
    endfunction

    always @(negedge clk_tb) begin
        cyc++;
        if (chk) begin
            due_now = sb.size() > 0 && sb[0].due == cyc;
            exp_v   = due_now && !flush;
            exp_r   = sb.size() == 0 || (due_now && !sb[0].byp);
            if (due_now) begin
                res_hold = sb[0].res;
                st_hold  = sb[0].st;
                void'(sb.pop_front());
            end
            check("sb_valid", valid, exp_v);
            check("sb_ready", ready, exp_r);
            check("sb_res", res, res_hold);
            check("sb_sticky", sticky, st_hold);
            if (rst || flush) sb.delete();
            else if (do_sqrt && exp_r) begin
                model(s, odd, inv, m_res, m_st);
                it.byp = spc;
                it.res = spc ? 16'h0 : m_res;
                it.st  = spc ? 1'b0 : m_st;
                it.due = cyc + (spc ? 1 : inv ? 33 : 17);
                sb.push_back(it);
            end
            if (rst) begin
                res_hold = '0;
                st_hold  = 1'b0;
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk_tb); #1;
            n++;
        end
        check("wait_ready", ready, 1);
    endtask

    task automatic run_op(input string nm, input logic [7:0] sv, input bit ov, input bit iv, input bit sp,
                          input logic [15:0] er, input bit es, input int el);
        int n;
        wait_ready();
        s = sv; odd = ov; inv = iv; spc = sp; do_sqrt = 1;
        @(posedge clk_tb); #1;
        do_sqrt = 0; spc = 0;
        s = 8'($urandom); odd = 1'($urandom); inv = 1'($urandom);
        n = 0;
        do begin
            @(negedge clk_tb);
            n++;
        end while (!valid && n < 100);
        check({nm, "_lat"}, n, el);
        check({nm, "_res"}, res, er);
        check({nm, "_sticky"}, sticky, es);
        if (sp) check({nm, "_ready"}, ready, 0);
    endtask

    initial begin
        int n, m;
        logic [15:0] r1, r2, r_before;
        rst = 1; do_sqrt = 0; s = 0; odd = 0; inv = 0; spc = 0; flush = 0;
        res_hold = '0; st_hold = 0;
        model(8'h80, 0, 0, m_res, m_st); check("pin_80e", {m_res, 15'h0, m_st}, {16'h8000, 16'h0});
        model(8'h80, 1, 0, m_res, m_st); check("pin_80o", {m_res, 15'h0, m_st}, {16'hB504, 16'h1});
        model(8'h90, 1, 0, m_res, m_st); check("pin_90o", {m_res, 15'h0, m_st}, {16'hC000, 16'h0});
        model(8'h80, 1, 1, m_res, m_st); check("pin_inv80o", {m_res, 15'h0, m_st}, {16'h5A82, 16'h1});
        model(8'h80, 0, 1, m_res, m_st); check("pin_inv80e", {m_res, 15'h0, m_st}, {16'h8000, 16'h0});
        repeat (3) @(posedge clk_tb);
        #1;
        check("rst_ready", ready, 1);
        check("rst_valid", valid, 0);
        check("rst_res", res, 0);
        check("rst_sticky", sticky, 0);
        rst = 0; chk = 1;

        run_op("sqrt80e", 8'h80, 0, 0, 0, 16'h8000, 0, 17);
        run_op("sqrt80o", 8'h80, 1, 0, 0, 16'hB504, 1, 17);
        run_op("sqrt90o", 8'h90, 1, 0, 0, 16'hC000, 0, 17);
        run_op("inv80o", 8'h80, 1, 1, 0, 16'h5A82, 1, 33);
        run_op("inv80e", 8'h80, 0, 1, 0, 16'h8000, 0, 33);
        run_op("bypass", 8'h5A, 1, 1, 1, 16'h0000, 0, 1);

        // back-to-back: request stays high, second operand set after the first accept
        wait_ready();
        s = 8'h80; odd = 0; inv = 0; do_sqrt = 1;
        @(posedge clk_tb); #1;
        s = 8'h90; odd = 1;
        n = 0;
        while (!valid && n < 100) begin @(negedge clk_tb); n++; end
        r1 = res;
        @(posedge clk_tb); #1;
        do_sqrt = 0;
        m = 0;
        do begin @(negedge clk_tb); m++; end while (!valid && m < 100);
        r2 = res;
        check("b2b_lat1", n, 17);
        check("b2b_res1", r1, 16'h8000);
        check("b2b_gap", m, 17);
        check("b2b_res2", r2, 16'hC000);

        // flush mid-root, then reset mid-root
        wait_ready();
        r_before = res;
        s = 8'hA7; odd = 1; inv = 1; do_sqrt = 1;
        @(posedge clk_tb); #1;
        do_sqrt = 0;
        repeat (5) @(posedge clk_tb);
        #1; flush = 1;
        @(posedge clk_tb); #1; flush = 0;
        check("flush_ready", ready, 1);
        check("flush_valid", valid, 0);
        check("flush_res", res, r_before);
        s = 8'hC3; odd = 0; inv = 0; do_sqrt = 1;
        @(posedge clk_tb); #1;
        do_sqrt = 0;
        repeat (3) @(posedge clk_tb);
        #1; rst = 1;
        @(posedge clk_tb); #1; rst = 0;
        check("rst2_ready", ready, 1);
        check("rst2_res", res, 0);
        check("rst2_valid", valid, 0);
        repeat (40) @(posedge clk_tb);
        #1;

        // flush during the result cycle hides that pulse
        s = 8'h80; odd = 1; inv = 0; do_sqrt = 1;
        @(posedge clk_tb); #1;
        do_sqrt = 0;
        repeat (16) @(posedge clk_tb);
        #1; flush = 1;
        #1;
        check("flush_done_valid", valid, 0);
        @(posedge clk_tb); #1; flush = 0;
        check("flush_done_ready", ready, 1);

        // flush beats a same-cycle request
        s = 8'h80; odd = 0; inv = 0; do_sqrt = 1; flush = 1;
        @(posedge clk_tb); #1;
        do_sqrt = 0; flush = 0;
        check("flush_req_ready", ready, 1);
        repeat (20) @(posedge clk_tb);
        #1;

        for (int i = 0; i < 1000; i++) begin
            wait_ready();
            spc = $urandom_range(0, 9) == 0;
            s = spc ? 8'($urandom) : {1'b1, 7'($urandom)};
            odd = 1'($urandom); inv = 1'($urandom);
            flush = $urandom_range(0, 49) == 0;
            do_sqrt = 1;
            @(posedge clk_tb); #1;
            do_sqrt = 0; spc = 0; flush = 0;
            s = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk_tb);
            #1;
            if ($urandom_range(0, 39) == 0) begin
                flush = 1;
                @(posedge clk_tb); #1;
                flush = 0;
            end
        end
        repeat (60) @(posedge clk_tb);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
